// File: rtl/plot_arbiter.sv
// plot_arbiter: merges the frame-painter and cell-painter pixel streams into a
// single registered pixel port for the VGA adapter. A source that starts a
// multi-pixel burst (last=0) keeps the port locked until its last pixel.
// The frame painter has priority when both request from IDLE.
// Optional feature: define PLOT_ARBITER_CLIP_EN to suppress the plot strobe for
// pixels outside SCREEN_W x SCREEN_H. The handshake, state and frame_done
// behaviour are the same in both builds.
module plot_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fp_valid,
    input  logic [7:0] fp_x,
    input  logic [6:0] fp_y,
    input  logic [2:0] fp_colour,
    input  logic       fp_last,
    output logic       fp_ready,
    input  logic       cp_valid,
    input  logic [7:0] cp_x,
    input  logic [6:0] cp_y,
    input  logic [2:0] cp_colour,
    input  logic       cp_last,
    output logic       cp_ready,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       frame_done,
    output logic       busy
);

`ifdef PLOT_ARBITER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_CELL
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_fp_ready;
    logic       w_cp_ready;
    logic       w_fp_xfer;
    logic       w_cp_xfer;
    logic [7:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_colour;
    logic       w_in_range;
    logic       w_plot_en;

    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_frame_done;

    // Ready signals depend only on state (and fp_valid in IDLE for priority)
    always_comb begin
        w_fp_ready = 1'b0;
        w_cp_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_fp_ready = 1'b1;
                w_cp_ready = ~fp_valid;
            end
            S_FRAME: w_fp_ready = 1'b1;
            S_CELL:  w_cp_ready = 1'b1;
            default: begin
                w_fp_ready = 1'b0;
                w_cp_ready = 1'b0;
            end
        endcase
    end

    assign w_fp_xfer = fp_valid & w_fp_ready;
    assign w_cp_xfer = cp_valid & w_cp_ready;

    // Next-state: a burst locks on a non-last transfer and releases on its last pixel
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fp_xfer && !fp_last) begin
                    w_next = S_FRAME;
                end else if (w_cp_xfer && !cp_last) begin
                    w_next = S_CELL;
                end
            end
            S_FRAME: begin
                if (w_fp_xfer && fp_last) begin
                    w_next = S_IDLE;
                end
            end
            S_CELL: begin
                if (w_cp_xfer && cp_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Select the transferring source's pixel and decide whether it is plotted
    always_comb begin
        w_x        = fp_x;
        w_y        = fp_y;
        w_colour   = fp_colour;
        if (w_cp_xfer) begin
            w_x      = cp_x;
            w_y      = cp_y;
            w_colour = cp_colour;
        end
        w_in_range = (int'(w_x) < SCREEN_W) && (int'(w_y) < SCREEN_H);
        w_plot_en  = (w_fp_xfer | w_cp_xfer) & (~CLIP_EN | w_in_range);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Output pixel register: loads on a plotted transfer, otherwise holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
            r_plot       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_plot       <= w_plot_en;
            r_frame_done <= w_fp_xfer & fp_last;
            if (w_plot_en) begin
                r_x      <= w_x;
                r_y      <= w_y;
                r_colour <= w_colour;
            end
        end
    end

    assign fp_ready   = w_fp_ready;
    assign cp_ready   = w_cp_ready;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign colour_out = r_colour;
    assign plot       = r_plot;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: scoreboard bench for plot_arbiter. The driver applies
// directed and random pixel streams, checks the handshake against a lock-owner
// model and queues the pixels expected one cycle later; a separate monitor
// compares every presented output against that queue.
module tb_plot_arbiter;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fp_valid = 1'b0;
    logic [7:0] fp_x = '0;
    logic [6:0] fp_y = '0;
    logic [2:0] fp_colour = '0;
    logic       fp_last = 1'b0;
    logic       fp_ready;
    logic       cp_valid = 1'b0;
    logic [7:0] cp_x = '0;
    logic [6:0] cp_y = '0;
    logic [2:0] cp_colour = '0;
    logic       cp_last = 1'b0;
    logic       cp_ready;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       frame_done;
    logic       busy;

    plot_arbiter #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst(rst),
        .fp_valid(fp_valid), .fp_x(fp_x), .fp_y(fp_y), .fp_colour(fp_colour),
        .fp_last(fp_last), .fp_ready(fp_ready),
        .cp_valid(cp_valid), .cp_x(cp_x), .cp_y(cp_y), .cp_colour(cp_colour),
        .cp_last(cp_last), .cp_ready(cp_ready),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit pl;
        bit fd;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    // Lock owner: 0 nobody, 1 frame painter, 2 cell painter
    int   owner  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference for the cycle currently on the inputs
    task automatic eval();
        bit efr, ecr, fx, cx, inr, pl, fd;
        int x, y, c;
        efr = (owner != 2);
        ecr = (owner == 2) || (owner == 0 && !fp_valid);
        chk("fp_ready", fp_ready, efr);
        chk("cp_ready", cp_ready, ecr);
        chk("busy", busy, owner != 0);
        fx = fp_valid && efr;
        cx = cp_valid && ecr;
        if (fx || cx) begin
            x  = fx ? int'(fp_x) : int'(cp_x);
            y  = fx ? int'(fp_y) : int'(cp_y);
            c  = fx ? int'(fp_colour) : int'(cp_colour);
            inr = (x < SW) && (y < SH);
`ifdef PLOT_ARBITER_CLIP_EN
            pl = inr;
`else
            pl = 1'b1;
`endif
            fd = fx && fp_last;
            if (pl || fd) q.push_back('{cyc + 1, pl, fd, x, y, c});
            if (fx) owner = fp_last ? 0 : 1;
            else    owner = cp_last ? 0 : 2;
        end
    endtask

    task automatic step(input bit fv, input int fx, input int fy, input int fc, input bit fl,
                        input bit cv, input int cx, input int cy, input int cc, input bit cl);
        @(posedge clk);
        #2;
        fp_valid = fv; fp_x = 8'(fx); fp_y = 7'(fy); fp_colour = 3'(fc); fp_last = fl;
        cp_valid = cv; cp_x = 8'(cx); cp_y = 7'(cy); cp_colour = 3'(cc); cp_last = cl;
        #1;
        eval();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset applied mid-cycle with new pending requests
    task automatic do_reset(input bit fv, input bit cv);
        fp_valid = fv; fp_x = 8'd77; fp_y = 7'd33; fp_colour = 3'd6; fp_last = 1'b1;
        cp_valid = cv; cp_last = 1'b1;
        rst = 1'b0;
        q.delete();
        owner = 0;
        #1;
        chk("rst_plot", plot, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_colour", colour_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fp_ready", fp_ready, 1);
        chk("rst_cp_ready", cp_ready, !fv);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        eval();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output
    initial begin : monitor
        int lx, ly, lc;
        exp_t e;
        lx = 0; ly = 0; lc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("rst_hold_plot", plot, 0);
                chk("rst_hold_x", x_out, 0);
                lx = 0; ly = 0; lc = 0;
            end else begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    chk("missed_output_due", q[0].due, cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk("plot", plot, e.pl);
                    chk("frame_done", frame_done, e.fd);
                    if (e.pl) begin
                        lx = e.x; ly = e.y; lc = e.c;
                    end
                    chk("x_out", x_out, lx);
                    chk("y_out", y_out, ly);
                    chk("colour_out", colour_out, lc);
                end else begin
                    chk("plot_idle", plot, 0);
                    chk("frame_done_idle", frame_done, 0);
                    chk("x_hold", x_out, lx);
                    chk("y_hold", y_out, ly);
                    chk("colour_hold", colour_out, lc);
                end
            end
        end
    end

    initial begin : driver
        // Power-on reset
        #1;
        chk("por_plot", plot, 0);
        chk("por_x", x_out, 0);
        chk("por_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        eval();
        idle();

        // Single-pixel frame: plotted next cycle with frame_done, no lock
        step(1, 5, 7, 4, 1, 0, 0, 0, 0, 0);
        idle();

        // Simultaneous requests: frame wins and holds the port for the whole frame
        step(1, 10, 11, 2, 0, 1, 50, 51, 5, 1);
        step(1, 12, 13, 3, 0, 1, 50, 51, 5, 1);
        step(1, 14, 15, 1, 1, 1, 50, 51, 5, 1);
        step(0, 0, 0, 0, 0, 1, 50, 51, 5, 1);
        idle();

        // Frame with a three-cycle gap
        step(1, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 9, 9, 9, 0, 1, 60, 61, 2, 0);
        step(1, 3, 4, 5, 0, 1, 60, 61, 2, 0);
        step(1, 6, 7, 6, 1, 0, 0, 0, 0, 0);
        idle();

        // 4x4 cell block with the frame painter requesting from pixel 3
        for (int i = 0; i < 16; i++)
            step(i >= 2, 1, 2, 3, 1, 1, 40 + i % 4, 20 + i / 4, i % 8, i == 15);
        step(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
        idle();

        // Reset after five pixels of a cell burst; pending frame pixel wins afterwards
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 1, 90 + i, 30, i, 0);
        do_reset(1, 1);
        idle();

        // Coordinate boundary pixels
        step(1, 160, 10, 7, 1, 0, 0, 0, 0, 0);
        step(1, 159, 119, 2, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 255, 127, 5, 1);
        idle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 2) != 0, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 7), $urandom_range(0, 5) == 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 7), $urandom_range(0, 5) == 0);
            end
        end

        idle();
        idle();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
